gcd_unit: RTL and testbench

Parametrised, handshaked greatest-common-divisor engine; the successor to the fixed-width subtractive GCD core. It accepts one pair of signed WIDTH-bit operands over a valid/ready input port and computes gcd(|a|,|b|) with the binary (Stein) algorithm, one step per cycle. It returns the unsigned result and a step count over a valid/ready output port. It sits behind a request queue in the arithmetic test harness and drives a result FIFO, so both ports must tolerate arbitrary backpressure.

---
 rtl/gcd_unit.sv | 152 +++++++++++++++
 tb/tb_gcd_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// Handshaked binary (Stein) GCD engine: gcd(|a|,|b|) of signed operands, one step per cycle.
// Optional build macro GCD_UNIT_TRACE_EN adds simulation trace messages on start and completion.
module gcd_unit #(
    parameter int WIDTH   = 64,
    parameter int CYCLE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [CYCLE_W-1:0] out_cycles
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_x_nxt;
    logic [WIDTH-1:0]   w_y_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      w_k_nxt;
    logic [CYCLE_W-1:0] r_cycles;
    logic [CYCLE_W-1:0] w_cycles_nxt;
    logic               w_accept;

    // Unsigned magnitude: the most negative value maps onto 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? (~v + WIDTH'(1'b1)) : v;
    endfunction

    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] c);
        sat_inc = (c == {CYCLE_W{1'b1}}) ? c : (c + CYCLE_W'(1'b1));
    endfunction

    assign in_ready   = (r_state == IDLE) && !reset;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == DONE);
    assign out_result = r_result;
    assign out_cycles = r_cycles;

    // Next-state and datapath update for one Stein step per cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_k_nxt      = r_k;
        w_cycles_nxt = r_cycles;
        w_result_nxt = r_result;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_x_nxt      = magnitude(in_a);
                    w_y_nxt      = magnitude(in_b);
                    w_k_nxt      = {KW{1'b0}};
                    w_cycles_nxt = {CYCLE_W{1'b0}};
                    w_state_nxt  = SHIFT;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            SHIFT: begin
                w_cycles_nxt = sat_inc(r_cycles);
                if ((r_x == {WIDTH{1'b0}}) || (r_y == {WIDTH{1'b0}})) begin
                    w_result_nxt = r_x | r_y;
                    w_state_nxt  = DONE;
                end else if (!r_x[0] && !r_y[0]) begin
                    w_x_nxt = r_x >> 1;
                    w_y_nxt = r_y >> 1;
                    w_k_nxt = r_k + KW'(1'b1);
                end else begin
                    w_state_nxt = ITER;
                end
            end
            ITER: begin
                w_cycles_nxt = sat_inc(r_cycles);
                // y never reaches zero here, so x==0 is the only exit.
                if (r_x == {WIDTH{1'b0}}) begin
                    w_result_nxt = r_y << r_k;
                    w_state_nxt  = DONE;
                end else if (!r_x[0]) begin
                    w_x_nxt = r_x >> 1;
                end else if (!r_y[0]) begin
                    w_y_nxt = r_y >> 1;
                end else if (r_x >= r_y) begin
                    w_x_nxt = r_x - r_y;
                end else begin
                    w_y_nxt = r_y - r_x;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_x      <= {WIDTH{1'b0}};
            r_y      <= {WIDTH{1'b0}};
            r_k      <= {KW{1'b0}};
            r_cycles <= {CYCLE_W{1'b0}};
            r_result <= {WIDTH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_k      <= w_k_nxt;
            r_cycles <= w_cycles_nxt;
            r_result <= w_result_nxt;
        end
    end

`ifdef GCD_UNIT_TRACE_EN
    // Simulation trace of each accepted pair and each completed result.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            $display("gcd_unit: start %X %X", in_a, in_b);
        end
        if (!reset && (r_state != DONE) && (w_state_nxt == DONE)) begin
            $display("gcd_unit: result %X in %0d cycles", w_result_nxt, w_cycles_nxt);
        end
    end
`else
    // Default build carries no trace logic.
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: directed cases at WIDTH 64 and 8, randomized ops at WIDTH 16.
module tb_gcd_unit;

    logic        clock = 1'b0;
    logic        reset;
    int          dsel;
    logic        tb_in_valid;
    logic        tb_out_ready;
    logic [63:0] tb_a;
    logic [63:0] tb_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    logic        d64_iv, d64_or, d64_ir, d64_ov;
    logic [63:0] d64_res;
    logic [15:0] d64_cyc;
    logic        d8_iv, d8_or, d8_ir, d8_ov;
    logic [7:0]  d8_res;
    logic [15:0] d8_cyc;
    logic        d16_iv, d16_or, d16_ir, d16_ov;
    logic [15:0] d16_res;
    logic [15:0] d16_cyc;

    assign d64_iv = tb_in_valid  && (dsel == 64);
    assign d64_or = tb_out_ready && (dsel == 64);
    assign d8_iv  = tb_in_valid  && (dsel == 8);
    assign d8_or  = tb_out_ready && (dsel == 8);
    assign d16_iv = tb_in_valid  && (dsel == 16);
    assign d16_or = tb_out_ready && (dsel == 16);

    gcd_unit #(.WIDTH(64), .CYCLE_W(16)) u_gcd64 (
        .clock(clock), .reset(reset), .in_valid(d64_iv), .in_ready(d64_ir),
        .in_a(tb_a), .in_b(tb_b), .out_valid(d64_ov), .out_ready(d64_or),
        .out_result(d64_res), .out_cycles(d64_cyc));

    gcd_unit #(.WIDTH(8), .CYCLE_W(16)) u_gcd8 (
        .clock(clock), .reset(reset), .in_valid(d8_iv), .in_ready(d8_ir),
        .in_a(tb_a[7:0]), .in_b(tb_b[7:0]), .out_valid(d8_ov), .out_ready(d8_or),
        .out_result(d8_res), .out_cycles(d8_cyc));

    gcd_unit #(.WIDTH(16), .CYCLE_W(16)) u_gcd16 (
        .clock(clock), .reset(reset), .in_valid(d16_iv), .in_ready(d16_ir),
        .in_a(tb_a[15:0]), .in_b(tb_b[15:0]), .out_valid(d16_ov), .out_ready(d16_or),
        .out_result(d16_res), .out_cycles(d16_cyc));

    logic        s_ir, s_ov;
    logic [63:0] s_res;
    logic [15:0] s_cyc;

    always_comb begin
        s_ir  = 1'b0;
        s_ov  = 1'b0;
        s_res = 64'd0;
        s_cyc = 16'd0;
        case (dsel)
            8:       begin s_ir = d8_ir;  s_ov = d8_ov;  s_res = {56'd0, d8_res};  s_cyc = d8_cyc;  end
            16:      begin s_ir = d16_ir; s_ov = d16_ov; s_res = {48'd0, d16_res}; s_cyc = d16_cyc; end
            default: begin s_ir = d64_ir; s_ov = d64_ov; s_res = d64_res;          s_cyc = d64_cyc; end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: Euclid on magnitudes, deliberately unlike the engine's algorithm.
    function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 64'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int pre_gap,
                          input int post_gap, output logic [63:0] res, output int cyc,
                          output int lat);
        int n;
        tb_a = a;
        tb_b = b;
        repeat (pre_gap) tick();
        tb_in_valid = 1'b1;
        n = 0;
        while (!s_ir && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(s_ir), 64'd1);
        tick();
        tb_in_valid = 1'b0;
        lat = 0;
        while (!s_ov && lat < 400) begin
            tick();
            lat++;
        end
        chk("done_seen", 64'(s_ov), 64'd1);
        res = s_res;
        cyc = int'(s_cyc);
        repeat (post_gap) tick();
        tb_out_ready = 1'b1;
        tick();
        tb_out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        int          cyc, lat, n, sa, sb;
        longint unsigned ma, mb;
        logic [63:0] ra, rb;

        reset = 1'b1;
        tb_in_valid = 1'b0;
        tb_out_ready = 1'b0;
        tb_a = 64'd0;
        tb_b = 64'd0;
        dsel = 64;
        repeat (3) tick();
        chk("rst_in_ready", 64'(s_ir), 64'd0);
        chk("rst_out_valid", 64'(s_ov), 64'd0);
        chk("rst_result", s_res, 64'd0);
        chk("rst_cycles", 64'(s_cyc), 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", 64'(s_ir), 64'd1);

        run_op(64'd48, 64'd18, 0, 0, res, cyc, lat);
        chk("g48_18_result", res, 64'd6);
        chk("g48_18_cycles", 64'(cyc), 64'd9);
        chk("g48_18_latency", 64'(lat), 64'd9);
        chk("handoff_ready", 64'(s_ir), 64'd1);

        run_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 2, res, cyc, lat);
        chk("g0_m5_result", res, 64'd5);
        chk("g0_m5_cycles", 64'(cyc), 64'd1);
        run_op(64'd0, 64'd0, 0, 0, res, cyc, lat);
        chk("g0_0_result", res, 64'd0);
        chk("g0_0_cycles", 64'(cyc), 64'd1);

        // Backpressure: hold out_ready low while a new request waits.
        tb_a = 64'd48;
        tb_b = 64'd18;
        tb_in_valid = 1'b1;
        tick();
        tb_in_valid = 1'b0;
        n = 0;
        while (!s_ov && n < 100) begin
            tick();
            n++;
        end
        chk("bp_done", 64'(s_ov), 64'd1);
        tb_a = 64'd100;
        tb_b = 64'd75;
        tb_in_valid = 1'b1;
        repeat (20) begin
            tick();
            chk("bp_valid", 64'(s_ov), 64'd1);
            chk("bp_result", s_res, 64'd6);
            chk("bp_cycles", 64'(s_cyc), 64'd9);
            chk("bp_in_ready", 64'(s_ir), 64'd0);
        end
        tb_out_ready = 1'b1;
        tick();
        tb_out_ready = 1'b0;
        chk("hs_out_valid", 64'(s_ov), 64'd0);
        chk("hs_in_ready", 64'(s_ir), 64'd1);
        tick();
        chk("bp_accepted", 64'(s_ir), 64'd0);
        tb_in_valid = 1'b0;
        n = 0;
        while (!s_ov && n < 400) begin
            tick();
            n++;
        end
        chk("bp2_result", s_res, 64'd25);
        tb_out_ready = 1'b1;
        tick();
        tb_out_ready = 1'b0;

        // Reset in the middle of a long operation.
        tb_a = 64'h0000_0100_0000_0000;
        tb_b = 64'd3;
        tb_in_valid = 1'b1;
        tick();
        tb_in_valid = 1'b0;
        repeat (3) tick();
        chk("mid_busy", 64'(s_ir), 64'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(s_ov), 64'd0);
        chk("mid_rst_ready", 64'(s_ir), 64'd0);
        chk("mid_rst_result", s_res, 64'd0);
        reset = 1'b0;
        #1;
        chk("mid_idle", 64'(s_ir), 64'd1);
        run_op(64'd12, 64'd8, 0, 0, res, cyc, lat);
        chk("g12_8_result", res, 64'd4);

        dsel = 8;
        #1;
        run_op(64'h0000_0000_0000_0080, 64'd64, 0, 0, res, cyc, lat);
        chk("w8_m128_64", res, 64'h40);
        chk("w8_cyc_bound", 64'(cyc <= 26), 64'd1);
        run_op(64'h0000_0000_0000_0080, 64'h0000_0000_0000_0080, 0, 1, res, cyc, lat);
        chk("w8_m128_m128", res, 64'h80);

        dsel = 16;
        #1;
        for (int i = 0; i < 1000; i++) begin
            ra = {48'd0, 16'($urandom)};
            rb = {48'd0, 16'($urandom)};
            if (i % 50 == 0) ra = 64'h8000;
            if (i % 77 == 0) rb = 64'd0;
            sa = int'($signed(ra[15:0]));
            sb = int'($signed(rb[15:0]));
            ma = longint'((sa < 0) ? -sa : sa);
            mb = longint'((sb < 0) ? -sb : sb);
            run_op(ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), res, cyc, lat);
            chk("r16_result", res, 64'(ref_gcd(ma, mb)));
            chk("r16_cyc_bound", 64'(cyc <= 50), 64'd1);
            chk("r16_latency", 64'(lat), 64'(cyc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
